// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver states, frame constants and baud arithmetic.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input with a configurable reset level.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q <= RESET_VALUE;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, valid strobe and framing-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clock,
  input  logic reset,
  input  logic serial_rx,
  output logic [UART_DATA_BITS-1:0] rx_data_out,
  output logic rx_valid,
  output logic rx_framing_error,
  output logic rx_busy
);
  localparam int C = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CW = $clog2(C);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(C / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(C - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);
  rx_state_t state;
  logic rx_s;
  logic tick;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [UART_DATA_BITS-1:0] shift;
  uart_sync2 #(.RESET_VALUE(1'b1)) sync (
    .clock(clock),
    .reset(reset),
    .d(serial_rx),
    .q(rx_s)
  );
  // START waits half a bit to land mid-bit; every later sample is a full bit apart
  assign tick = cnt == (state == START ? HALF_LAST : BIT_LAST);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      rx_data_out <= '0;
      rx_valid <= 1'b0;
      rx_framing_error <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_framing_error <= 1'b0;
      cnt <= tick ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            rx_busy <= 1'b1;
          end
        end
        START: if (tick) begin
          state <= rx_s ? IDLE : DATA;
          rx_busy <= !rx_s;
          idx <= '0;
        end
        DATA: if (tick) begin
          shift[idx] <= rx_s;
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) state <= STOP;
        end
        STOP: if (tick) begin
          state <= rx_s ? IDLE : WAIT_HIGH;
          rx_busy <= !rx_s;
          rx_valid <= rx_s;
          rx_framing_error <= !rx_s;
          if (rx_s) rx_data_out <= shift;
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
